// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU front end: fetch FSM states, SPI
// opcode and instruction width.
package tiny_cpu_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam int unsigned INSTR_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4,
        ST_HOLD = 3'd5,
        ST_GAP  = 3'd6
    } fetch_state_e;

    // Address of the halfword that directly follows addr; wraps at 16 bits.
    function automatic logic [15:0] seq_next_addr(input logic [15:0] addr);
        return addr + 16'd2;
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: two clk cycles per bit, MSB-first transmit shifter,
// receive shifter and bit counter with a last-bit flag for the fetch FSM.
module spi_bit_engine
    import tiny_cpu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [31:0]        i_load_word,
    input  logic               i_rx_start,
    input  logic               i_shift,
    input  logic [5:0]         i_last_bit,
    input  logic               i_miso,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic               o_bit_done,
    output logic [INSTR_W-1:0] o_rx_word
);

    logic               r_phase;
    logic               r_sclk;
    logic               r_mosi;
    logic [31:0]        r_tx_sh;
    logic [INSTR_W-1:0] r_rx_sh;
    logic [5:0]         r_bit_cnt;

    // Phase toggle, shifters and bit counter; MISO is sampled on the edge that ends phase 1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_tx_sh   <= 32'h0000_0000;
            r_rx_sh   <= '0;
            r_bit_cnt <= 6'd0;
        end else if (i_load) begin
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= i_load_word[31];
            r_tx_sh   <= {i_load_word[30:0], 1'b0};
            r_bit_cnt <= 6'd0;
        end else if (i_rx_start) begin
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_tx_sh   <= 32'h0000_0000;
            r_bit_cnt <= 6'd0;
        end else if (i_shift) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
                r_sclk  <= 1'b1;
            end else begin
                r_phase   <= 1'b0;
                r_sclk    <= 1'b0;
                r_mosi    <= r_tx_sh[31];
                r_tx_sh   <= {r_tx_sh[30:0], 1'b0};
                r_rx_sh   <= {r_rx_sh[INSTR_W-2:0], i_miso};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
        end else begin
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end
    end

    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_bit_done = r_phase && (r_bit_cnt == i_last_bit);
    // Word as it stands once the bit being sampled on this edge is included.
    assign o_rx_word  = {r_rx_sh[INSTR_W-2:0], i_miso};

endmodule

// File: rtl/spi_instr_fetch.sv
// Instruction fetch over SPI read (0x03) with optional reuse of the open
// transaction for sequential halfword fetches.
module spi_instr_fetch
    import tiny_cpu_pkg::*;
#(
    parameter logic [7:0] CMD_READ = SPI_CMD_READ,
    parameter logic [7:0] ADDR_HI  = 8'h00,
    parameter bit         SEQ_EN   = 1'b1
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [15:0]        fetch_addr_in,
    input  logic               fetch_req_in,
    input  logic               abort_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid_out,
    output logic               busy_out,
    output logic               spi_cs_n_out,
    output logic               spi_sclk_out,
    output logic               spi_mosi_out,
    input  logic               spi_miso_in
);

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic [15:0]        r_addr;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_busy;
    logic               r_cs_n;

    logic               w_load;
    logic               w_rx_start;
    logic               w_shift;
    logic               w_addr_we;
    logic [5:0]         w_last_bit;
    logic               w_bit_done;
    logic [INSTR_W-1:0] w_rx_word;
    logic [15:0]        w_req_addr;
    logic [15:0]        w_load_addr;
    logic               w_unused_addr_lsb;

    assign w_req_addr        = {fetch_addr_in[15:1], 1'b0};
    assign w_unused_addr_lsb = fetch_addr_in[0];
    // A cold start from IDLE loads the shifter in the same cycle the address is latched.
    assign w_load_addr       = (r_state == ST_IDLE) ? w_req_addr : r_addr;

    spi_bit_engine u_bit_engine (
        .i_clk       (clk_in),
        .i_reset     (reset_in),
        .i_load      (w_load),
        .i_load_word ({CMD_READ, ADDR_HI, w_load_addr}),
        .i_rx_start  (w_rx_start),
        .i_shift     (w_shift),
        .i_last_bit  (w_last_bit),
        .i_miso      (spi_miso_in),
        .o_sclk      (spi_sclk_out),
        .o_mosi      (spi_mosi_out),
        .o_bit_done  (w_bit_done),
        .o_rx_word   (w_rx_word)
    );

    // Next-state and bit-engine control; abort overrides everything, including a same-cycle request.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_rx_start   = 1'b0;
        w_shift      = 1'b0;
        w_addr_we    = 1'b0;
        w_last_bit   = 6'd0;
        if (abort_in) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_req_in) begin
                        w_next_state = ST_CMD;
                        w_load       = 1'b1;
                        w_addr_we    = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    w_shift    = 1'b1;
                    w_last_bit = 6'd7;
                    if (w_bit_done) begin
                        w_next_state = ST_ADDR;
                    end else begin
                        w_next_state = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    w_last_bit = 6'd31;
                    if (w_bit_done) begin
                        w_next_state = ST_DATA;
                        w_rx_start   = 1'b1;
                    end else begin
                        w_shift      = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_last_bit = 6'd15;
                    if (w_bit_done) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_shift      = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_next_state = SEQ_EN ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (fetch_req_in) begin
                        w_addr_we = 1'b1;
                        if (w_req_addr == seq_next_addr(r_addr)) begin
                            w_next_state = ST_DATA;
                            w_rx_start   = 1'b1;
                        end else begin
                            w_next_state = ST_GAP;
                        end
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
                ST_GAP: begin
                    w_next_state = ST_CMD;
                    w_load       = 1'b1;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= 16'h0000;
        end else begin
            r_cs_n  <= (w_next_state == ST_IDLE) || (w_next_state == ST_GAP);
            r_busy  <= !((w_next_state == ST_IDLE) || (w_next_state == ST_HOLD));
            r_valid <= (w_next_state == ST_DONE);
            if (w_next_state == ST_DONE) begin
                r_instr <= w_rx_word;
            end
            if (w_addr_we) begin
                r_addr <= w_req_addr;
            end
        end
    end

    assign instr_out       = r_instr;
    assign instr_valid_out = r_valid;
    assign busy_out        = r_busy;
    assign spi_cs_n_out    = r_cs_n;

endmodule
